// File: rtl/ram_arb_pkg.sv
// Shared types and widths for the two-requester RAM arbiter.
// The RAM_ARB_RR_EN macro (see rr_arbiter) selects round-robin vs fixed priority.
package ram_arb_pkg;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 8;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  // One accepted transaction, held for its whole lifetime in the FSM.
  typedef struct packed {
    logic              id;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  // Converts a one-hot two-requester grant into the requester index.
  function automatic logic grant_to_id(input logic [NUM_REQ-1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant logic for two requesters: one-hot grant to the winning valid request.
// With RAM_ARB_RR_EN defined, contention alternates against the last grant;
// otherwise requester 0 always wins and last_grant is ignored.
module rr_arbiter
  import ram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               last_grant,
  output logic [NUM_REQ-1:0] grant
);

`ifdef RAM_ARB_RR_EN
  // Under contention, favour whichever requester was not granted last.
  always_comb begin
    grant = '0;
    if (valid[0] && valid[1]) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (valid[0]) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Fixed priority: requester 0 beats requester 1.
  always_comb begin
    grant = '0;
    if (valid[0]) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with registered read data.
// One transaction in flight: IDLE -> ISSUE -> (write) IDLE, or
// IDLE -> ISSUE -> RD_WAIT -> RESP -> IDLE for reads.
// Define RAM_ARB_RR_EN for round-robin contention; default is fixed priority.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          ram_cs,
  output logic                          ram_mode,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata,
  output logic                          busy
);

  state_t              state_q, state_d;
  txn_t                txn_q, txn_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [NUM_REQ-1:0]  grant;
  logic                last_grant;
  logic                win_id;

`ifdef RAM_ARB_RR_EN
  logic last_grant_q, last_grant_d;
  assign last_grant = last_grant_q;
`else
  assign last_grant = 1'b1;
`endif

  rr_arbiter u_rr_arbiter (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // RAM address/data come straight from the latch so they hold between transactions.
  assign ram_addr  = txn_q.addr;
  assign ram_wdata = txn_q.wdata;
  assign rsp_rdata = rsp_rdata_q;

  // Next-state, latch updates and per-state outputs.
  always_comb begin
    state_d     = state_q;
    txn_d       = txn_q;
    rsp_rdata_d = rsp_rdata_q;
    req_ready   = '0;
    rsp_valid   = '0;
    ram_cs      = 1'b0;
    ram_mode    = 1'b0;
    busy        = (state_q != IDLE);
    win_id      = grant_to_id(grant);
`ifdef RAM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        // Gated by rst so ready reads zero for the whole reset pulse.
        req_ready = grant & {NUM_REQ{~rst}};
        if (|(req_valid & req_ready)) begin
          txn_d.id    = win_id;
          txn_d.wr    = req_wr[win_id];
          txn_d.addr  = req_addr[win_id];
          txn_d.wdata = req_wdata[win_id];
          state_d     = ISSUE;
`ifdef RAM_ARB_RR_EN
          last_grant_d = win_id;
`endif
        end
      end
      ISSUE: begin
        ram_cs   = 1'b1;
        ram_mode = txn_q.wr;
        state_d  = txn_q.wr ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        ram_cs      = 1'b1;
        rsp_rdata_d = ram_rdata;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid[txn_q.id] = 1'b1;
        state_d             = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and transaction registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      txn_q       <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      txn_q       <= txn_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef RAM_ARB_RR_EN
  // Last-grant register starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vectors, scoreboard queues for
// read responses and RAM writes, checked by independent monitors.
// Build with or without RAM_ARB_RR_EN; contention expectations follow the macro.
module tb_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req_valid;
  logic [1:0]           req_wr;
  logic [1:0][AW-1:0]   req_addr;
  logic [1:0][DW-1:0]   req_wdata;
  logic [1:0]           req_ready;
  logic [1:0]           rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 ram_cs;
  logic                 ram_mode;
  logic [AW-1:0]        ram_addr;
  logic [DW-1:0]        ram_wdata;
  logic [DW-1:0]        ram_rdata;
  logic                 busy;

  int checkCount = 0;
  int errorCount = 0;
  int cycleCount = 0;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         cycle;
  } rspExp_t;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
  } wrExp_t;

  rspExp_t rspQ[$];
  wrExp_t  wrQ[$];
  rspExp_t rspHead;
  wrExp_t  wrHead;

  bit [7:0] ramMem [1024];
  bit       ramWritten [1024];

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_cs    (ram_cs),
    .ram_mode  (ram_mode),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Behavioural RAM: registered read; unwritten locations read as addr[7:0]+0x11.
  always @(posedge clk) begin
    if (ram_cs === 1'b1) begin
      if (ram_mode === 1'b1) begin
        ramMem[ram_addr]     <= ram_wdata;
        ramWritten[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= ramWritten[ram_addr] ? ramMem[ram_addr] : ram_addr[7:0] + 8'h11;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (rsp_valid !== 2'b00) begin
      if (rspQ.size() == 0) begin
        checkOutput("unexpectedRsp", {30'd0, rsp_valid}, 32'd0);
      end else begin
        rspHead = rspQ.pop_front();
        checkOutput("rspValid", {30'd0, rsp_valid}, 32'(1 << rspHead.id));
        checkOutput("rspData", {24'd0, rsp_rdata}, {24'd0, rspHead.data});
        checkOutput("rspCycle", cycleCount, rspHead.cycle);
      end
    end
  end

  // Write monitor: every RAM write cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (ram_cs === 1'b1 && ram_mode === 1'b1) begin
      if (wrQ.size() == 0) begin
        checkOutput("unexpectedWrite", {22'd0, ram_addr}, 32'hFFFF_FFFF);
      end else begin
        wrHead = wrQ.pop_front();
        checkOutput("wrAddr", {22'd0, ram_addr}, {22'd0, wrHead.addr});
        checkOutput("wrData", {24'd0, ram_wdata}, {24'd0, wrHead.data});
      end
    end
  end

  // Lone request from an idle arbiter, with cycle-by-cycle RAM-side checks.
  task automatic applyStimulus(input int id, input bit wr, input logic [9:0] addr,
                               input logic [7:0] wdata, input logic [7:0] expData);
    req_valid[id] = 1'b1;
    req_wr[id]    = wr;
    req_addr[id]  = addr;
    req_wdata[id] = wdata;
    #1;
    checkOutput("readyLone", {30'd0, req_ready}, 32'(1 << id));
    checkOutput("busyIdle", {31'd0, busy}, 32'd0);
    if (wr) wrQ.push_back('{addr, wdata});
    else    rspQ.push_back('{id, expData, cycleCount + 3});
    nextCycle();
    req_valid[id] = 1'b0;
    #1;
    checkOutput("issueCs", {31'd0, ram_cs}, 32'd1);
    checkOutput("issueMode", {31'd0, ram_mode}, {31'd0, wr});
    checkOutput("issueAddr", {22'd0, ram_addr}, {22'd0, addr});
    checkOutput("issueBusy", {31'd0, busy}, 32'd1);
    checkOutput("issueReady", {30'd0, req_ready}, 32'd0);
    if (wr) checkOutput("issueWdata", {24'd0, ram_wdata}, {24'd0, wdata});
    nextCycle();
    #1;
    if (wr) begin
      checkOutput("postWrCs", {31'd0, ram_cs}, 32'd0);
      checkOutput("postWrBusy", {31'd0, busy}, 32'd0);
    end else begin
      checkOutput("rdWaitCs", {31'd0, ram_cs}, 32'd1);
      checkOutput("rdWaitMode", {31'd0, ram_mode}, 32'd0);
      checkOutput("rdWaitAddr", {22'd0, ram_addr}, {22'd0, addr});
      nextCycle();
      checkOutput("respCs", {31'd0, ram_cs}, 32'd0);
      checkOutput("respBusy", {31'd0, busy}, 32'd1);
      nextCycle();
      checkOutput("postRdBusy", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 2'b01;
    req_wr    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rstReady", {30'd0, req_ready}, 32'd0);
    checkOutput("rstRspValid", {30'd0, rsp_valid}, 32'd0);
    checkOutput("rstRspData", {24'd0, rsp_rdata}, 32'd0);
    checkOutput("rstCs", {31'd0, ram_cs}, 32'd0);
    checkOutput("rstMode", {31'd0, ram_mode}, 32'd0);
    checkOutput("rstAddr", {22'd0, ram_addr}, 32'd0);
    checkOutput("rstWdata", {24'd0, ram_wdata}, 32'd0);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    nextCycle();
    req_valid = 2'b00;
    rst       = 1'b0;
    nextCycle();

    $display("[TB] write 0x005=0xA5 then read it back from req0");
    applyStimulus(0, 1'b1, 10'h005, 8'hA5, 8'h00);
    applyStimulus(0, 1'b0, 10'h005, 8'h00, 8'hA5);

    $display("[TB] lone req1 write 0x200=0x3C");
    applyStimulus(1, 1'b1, 10'h200, 8'h3C, 8'h00);

    $display("[TB] req1 read 0x3FF while req0 waits");
    nextCycle();
    req_valid[1] = 1'b1;
    req_wr[1]    = 1'b0;
    req_addr[1]  = 10'h3FF;
    #1;
    checkOutput("holdGrant1", {30'd0, req_ready}, 32'd2);
    rspQ.push_back('{1, 8'h10, cycleCount + 3});
    nextCycle();
    req_valid    = 2'b01;
    req_wr[0]    = 1'b1;
    req_addr[0]  = 10'h123;
    req_wdata[0] = 8'h77;
    #1;
    checkOutput("holdReadyIssue", {30'd0, req_ready}, 32'd0);
    nextCycle();
    checkOutput("holdReadyRdWait", {30'd0, req_ready}, 32'd0);
    nextCycle();
    checkOutput("holdReadyResp", {30'd0, req_ready}, 32'd0);
    checkOutput("holdBusyResp", {31'd0, busy}, 32'd1);
    nextCycle();
    checkOutput("holdBusyIdle", {31'd0, busy}, 32'd0);
    checkOutput("holdGrant0", {30'd0, req_ready}, 32'd1);
    wrQ.push_back('{10'h123, 8'h77});
    nextCycle();
    req_valid = 2'b00;
    nextCycle();

    $display("[TB] reset during RD_WAIT of read 0x010");
    req_valid[0] = 1'b1;
    req_wr[0]    = 1'b0;
    req_addr[0]  = 10'h010;
    req_wdata[0] = 8'h5E;
    #1;
    checkOutput("abortGrant", {30'd0, req_ready}, 32'd1);
    nextCycle();
    req_valid = 2'b00;
    nextCycle();
    checkOutput("abortRdWaitCs", {31'd0, ram_cs}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abortCs", {31'd0, ram_cs}, 32'd0);
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("abortRspValid", {30'd0, rsp_valid}, 32'd0);
    checkOutput("abortRspData", {24'd0, rsp_rdata}, 32'd0);
    checkOutput("abortAddr", {22'd0, ram_addr}, 32'd0);
    checkOutput("abortWdata", {24'd0, ram_wdata}, 32'd0);
    checkOutput("abortMode", {31'd0, ram_mode}, 32'd0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    nextCycle();

    $display("[TB] both requesters valid every cycle");
    req_valid    = 2'b11;
    req_wr       = 2'b11;
    req_addr[0]  = 10'h0A0;
    req_wdata[0] = 8'h11;
    req_addr[1]  = 10'h0B1;
    req_wdata[1] = 8'h22;
    for (int k = 0; k < 4; k++) begin
      int winner;
`ifdef RAM_ARB_RR_EN
      winner = k % 2;
`else
      winner = 0;
`endif
      #1;
      checkOutput($sformatf("contendGrant%0d", k), {30'd0, req_ready}, 32'(1 << winner));
      if (winner == 0) wrQ.push_back('{10'h0A0, 8'h11});
      else             wrQ.push_back('{10'h0B1, 8'h22});
      nextCycle();
      checkOutput($sformatf("contendIssue%0d", k), {30'd0, req_ready}, 32'd0);
      nextCycle();
    end
    req_valid = 2'b00;
    #1;
    checkOutput("dropReady", {30'd0, req_ready}, 32'd0);
    nextCycle();
    checkOutput("dropBusy", {31'd0, busy}, 32'd0);

    repeat (4) nextCycle();
    checkOutput("rspQueueEmpty", rspQ.size(), 32'd0);
    checkOutput("wrQueueEmpty", wrQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
